// File: rtl/window_if.sv
// Pixel stream in, window column out, between the line buffer and its controller.
// The master drives the pixel stream and layer select; the slave returns the taps column.
interface window_if #(
    parameter int DATA_WIDTH = 8,
    parameter int KSIZE      = 5
);
    logic                        start;
    logic                        state;
    logic [DATA_WIDTH-1:0]       din;
    logic [KSIZE*DATA_WIDTH-1:0] taps;

    modport master (output start, output state, output din, input taps);
    modport slave  (input start, input state, input din, output taps);
endinterface

// File: rtl/window.sv
// Sliding-window line buffer: one long pixel shift chain, tapped every W entries,
// yielding one vertical KSIZE-pixel column of the convolution window per capture.
module window #(
    parameter int DATA_WIDTH = 8,
    parameter int KSIZE      = 5,
    parameter int W0         = 28,
    parameter int W1         = 12
) (
    input  logic     clk,
    input  logic     rstn,
    window_if.slave  bus
);
    // Sized for the wider layer; the narrower layer simply taps nearer the head.
    localparam int DEPTH = (KSIZE - 1) * W0 + 1;

    logic [DATA_WIDTH-1:0]       sr_reg [DEPTH];
    logic [KSIZE*DATA_WIDTH-1:0] taps_sel;

    // Registers rather than block RAM: reset must clear every entry asynchronously.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                sr_reg[i] <= '0;
            end
        end else if (bus.start) begin
            sr_reg[0] <= bus.din;
            for (int i = 1; i < DEPTH; i++) begin
                sr_reg[i] <= sr_reg[i-1];
            end
        end
    end

    // Row k of the column is the pixel captured k line-widths before the newest.
    generate
        for (genvar gi = 0; gi < KSIZE; gi++) begin : g_tap
            assign taps_sel[gi*DATA_WIDTH +: DATA_WIDTH] =
                bus.state ? sr_reg[gi*W1] : sr_reg[gi*W0];
        end
    endgenerate

    assign bus.taps = taps_sel;
endmodule

// File: tb/tb_window.sv
// Directed bench for the line buffer: a history model predicts each taps column,
// queued when a pixel is driven and compared after the capturing edge.
module tb_window;
    localparam int DW    = 8;
    localparam int K     = 5;
    localparam int W0    = 28;
    localparam int W1    = 12;
    localparam int DEPTH = (K - 1) * W0 + 1;

    logic clk;
    logic rstn;

    window_if #(.DATA_WIDTH(DW), .KSIZE(K)) bus ();

    window #(.DATA_WIDTH(DW), .KSIZE(K), .W0(W0), .W1(W1)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0]    hist  [$];
    logic [K*DW-1:0]  exp_q [$];
    logic [DW-1:0]    img   [784];

    function automatic logic [K*DW-1:0] model_taps();
        logic [K*DW-1:0] t;
        int w;
        w = bus.state ? W1 : W0;
        t = '0;
        for (int k = 0; k < K; k++) begin
            if (k * w < hist.size()) t[k*DW +: DW] = hist[k*w];
        end
        return t;
    endfunction

    task automatic check(input string tag, input logic [K*DW-1:0] obs,
                         input logic [K*DW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic compare_one(input string tag);
        logic [K*DW-1:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, observed %h", tag, bus.taps);
        end else begin
            e = exp_q.pop_front();
            check(tag, bus.taps, e);
        end
    endtask

    task automatic capture(input logic [DW-1:0] v, input string tag);
        @(negedge clk);
        bus.start = 1'b1;
        bus.din   = v;
        hist.push_front(v);
        if (hist.size() > DEPTH) void'(hist.pop_back());
        exp_q.push_back(model_taps());
        @(posedge clk);
        #1;
        compare_one(tag);
    endtask

    task automatic hold_cycle();
        @(negedge clk);
        bus.start = 1'b0;
        bus.din   = DW'($urandom);
        exp_q.push_back(model_taps());
        @(posedge clk);
        #1;
        compare_one("hold");
    endtask

    // Reset asserted mid-cycle; taps must clear before any clock edge.
    task automatic async_reset(input string tag);
        @(posedge clk);
        #3;
        bus.start = 1'b0;
        rstn = 1'b0;
        #1;
        check(tag, bus.taps, '0);
        hist.delete();
        exp_q.delete();
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        logic [K*DW-1:0] e;
        rstn      = 1'b0;
        bus.start = 1'b0;
        bus.state = 1'b0;
        bus.din   = '0;
        #3;
        check("reset_state", bus.taps, '0);
        @(negedge clk);
        rstn = 1'b1;

        // Layer-1 fill
        for (int n = 0; n <= 112; n++) begin
            capture(DW'(n), "l1_fill");
            if (n == 56)  check("l1_fill57",  bus.taps, 40'h00_00_00_1C_38);
            if (n == 112) check("l1_fill113", bus.taps, 40'h00_1C_38_54_70);
        end

        // Hold with start low
        for (int i = 0; i < 10; i++) hold_cycle();
        check("hold_const", bus.taps, 40'h00_1C_38_54_70);
        capture(8'd113, "resume");
        check("resume_const", bus.taps, 40'h01_1D_39_55_71);

        async_reset("async_reset");

        // Layer-2 width
        bus.state = 1'b1;
        for (int n = 0; n <= 48; n++) capture(DW'(n), "l2_fill");
        check("l2_const", bus.taps, 40'h00_0C_18_24_30);

        // Full 28x28 image
        async_reset("reset_img");
        bus.state = 1'b0;
        for (int i = 0; i < 784; i++) img[i] = DW'($urandom);
        for (int r = 0; r < 28; r++) begin
            for (int c = 0; c < 28; c++) begin
                capture(img[r*28+c], "image");
                if (r >= 4) begin
                    for (int k = 0; k < K; k++) e[k*DW +: DW] = img[(r-k)*28+c];
                    check("image_col", bus.taps, e);
                end
            end
        end

        // Reset mid-stream
        async_reset("reset_ms0");
        for (int i = 0; i < 60; i++) capture(DW'($urandom), "pre_reset");
        async_reset("reset_ms");
        capture(8'hAA, "post_reset");
        check("post_reset_const", bus.taps, 40'h00_00_00_00_AA);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/window.md
Name: window

Overview:
- Sliding-window line buffer for the CNN accelerator front end; feeds 8-bit pixels in raster order into the convolution engine.
- Each cycle it outputs one vertical column of a 5x5 window: five pixels from the same image column, spanning five consecutive image rows.
- Downstream logic forms the full 5x5 window by registering five successive columns.
- Line width is selectable for layer 1 (28-pixel input image) or layer 2 (12-pixel pooled feature map).

Parameters:
- DATA_WIDTH, 8, bits per pixel.
- KSIZE, 5, kernel height; number of pixels in the taps column.
- W0, 28, line width when state=0 (layer 1 input image).
- W1, 12, line width when state=1 (layer 2 pooled map).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rstn  input  1  asynchronous active-low reset.
- start  input  1  shift enable; when 1, din is captured on the clock edge.
- state  input  1  layer select: 0 gives line width W0, 1 gives line width W1.
- din  input  8  incoming pixel, raster order (row-major).
- taps  output  40  window column:
  - taps[7:0] = newest pixel.
  - taps[8k+7:8k] = pixel captured k*W captures before the newest, for k = 0..4.
  - taps[39:32] is therefore the oldest row.

Behaviour:
- Storage:
  - One shift chain sr[0..4*W0] of DATA_WIDTH-bit registers (113 entries).
  - sr[0] holds the most recent captured pixel.
- Shift:
  - On a rising clk edge with rstn=1 and start=1: sr[0] <= din and sr[i] <= sr[i-1] for i >= 1.
  - With start=0, all entries hold.
- Tap selection (combinational from registers):
  - W = W0 when state=0, W1 when state=1.
  - taps = {sr[4W], sr[3W], sr[2W], sr[W], sr[0]}.
  - state=0 uses indices 0, 28, 56, 84, 112; state=1 uses indices 0, 12, 24, 36, 48.
  - Entries beyond 4*W1 continue shifting while state=1 but are not output.
- Latency:
  - A pixel on din appears on taps[7:0] immediately after the capturing edge.
  - The same pixel reaches taps[8k+7:8k] after k*W further captures.
- Reset:
  - rstn=0 asynchronously clears every sr entry to 0, so taps=0.
  - Reset has priority over start.
  - Reset mid-stream discards all buffered rows.
- Fill:
  - Until 4W+1 pixels have been captured since reset, the upper taps show 0.
  - No valid flag is produced; the consumer counts captures itself.
- state change mid-stream:
  - Only the tap selection changes; buffer contents are neither flushed nor reordered.
  - The controller changes state only after reset or between layers.
- No wrap-around logic: the column index within a row is implicit in the capture count. Windows straddling row boundaries are produced and must be discarded downstream.
- din is sampled only when start=1; X on din while start=0 has no effect.

Test Plan:
- Reset: assert rstn=0 asynchronously mid-cycle -> taps=40'h0 immediately, without waiting for a clk edge.
- Layer-1 fill: state=0, start=1, din = n for n = 0..112 (one per cycle) -> after the 113th capture, taps = {8'd0, 8'd28, 8'd56, 8'd84, 8'd112}. After the 57th capture (n=56), taps = {8'd0, 8'd0, 8'd0, 8'd28, 8'd56}.
- Hold: after the layer-1 fill, drive start=0 and toggle din for 10 cycles -> taps unchanged at {0, 28, 56, 84, 112}. Then start=1, din=113 -> taps = {1, 29, 57, 85, 113}.
- Layer-2 width: reset, state=1, din = n for n = 0..48 -> taps = {8'd0, 8'd12, 8'd24, 8'd36, 8'd48}.
- Full image: 784 pixels of a 28x28 image with state=0 -> at capture index r*28+c (r >= 4), taps equals image[r-4..r][c], oldest row in the top byte.
- Reset mid-stream: after 60 captures, pulse rstn low, then capture din=0xAA -> taps = {0, 0, 0, 0, 8'hAA}.
